snake_dir_ctrl: RTL and testbench

Direction controller for the snake. It sits directly downstream of the four per-button debouncers and consumes their clean, synchronized levels. It turns button presses into a queued, legality-checked heading, and applies at most one turn per game-step `tick`. It drives the snake movement engine with the current heading and a turn pulse.

---
 rtl/snake_dir_ctrl.sv | 112 +++++++++++
 tb/tb_snake_dir_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: turns debounced button presses into a queued, legality-checked
// heading for the snake, applying at most one queued turn per game-step tick.
module snake_dir_ctrl #(
  parameter int unsigned QDEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  input  logic       tick,
  output logic [1:0] dir,
  output logic       turn,
  output logic [2:0] q_count
);

  localparam int unsigned   PW      = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PW-1:0] LAST    = PW'(QDEPTH - 1);
  localparam logic [2:0]    CNT_MAX = 3'(QDEPTH);
  localparam logic [1:0]    DIR_RST = 2'd1;

  logic [3:0]    prev_q;
  logic [1:0]    mem_q [QDEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [2:0]    count_q, count_d;
  logic [1:0]    dir_q, dir_d;
  logic          turn_q, turn_d;

  logic [3:0]    press;
  logic          press_vld;
  logic [1:0]    req;
  logic [PW-1:0] tail_last;
  logic [1:0]    ref_dir;
  logic          pop;
  logic          push;

  // Circular pointer advance, wrapping at QDEPTH.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign press = btn & ~prev_q;

  // Pick a single press this cycle, up > right > down > left.
  always_comb begin
    press_vld = 1'b1;
    req       = 2'd0;
    if (press[0])      req = 2'd0;
    else if (press[1]) req = 2'd1;
    else if (press[2]) req = 2'd2;
    else if (press[3]) req = 2'd3;
    else               press_vld = 1'b0;
  end

  // Validate the request against the newest queued heading (or dir if empty).
  always_comb begin
    tail_last = (tail_q == '0) ? LAST : tail_q - PW'(1);
    ref_dir   = (count_q != 3'd0) ? mem_q[tail_last] : dir_q;
    pop       = tick & (count_q != 3'd0);
    push      = press_vld
              & (req != ref_dir)
              & ((req ^ ref_dir) != 2'b10)
              & ((count_q != CNT_MAX) | pop);
  end

  // Next-state for queue pointers, occupancy, heading and turn pulse.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + 3'(push) - 3'(pop);
    dir_d   = dir_q;
    turn_d  = 1'b0;
    if (pop) begin
      head_d = ptr_inc(head_q);
      dir_d  = mem_q[head_q];
      turn_d = 1'b1;
    end
    if (push) begin
      tail_d = ptr_inc(tail_q);
    end
  end

  // Control registers; reset flushes the queue and forces heading right.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q  <= 4'b1111;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 3'd0;
      dir_q   <= DIR_RST;
      turn_q  <= 1'b0;
    end else begin
      prev_q  <= btn;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      turn_q  <= turn_d;
    end
  end

  // Queue storage; entries beyond the occupancy count are don't-care.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[tail_q] <= req;
    end
  end

  assign dir     = dir_q;
  assign turn    = turn_q;
  assign q_count = count_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed presses/ticks against a queue-based model,
// plus literal expectations at key points of the directed sequence.
module tb_snake_dir_ctrl;

  localparam int unsigned QDEPTH = 2;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn;
  logic       tick;
  logic [1:0] dir;
  logic       turn;
  logic [2:0] q_count;

  snake_dir_ctrl #(.QDEPTH(QDEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn     (btn),
    .tick    (tick),
    .dir     (dir),
    .turn    (turn),
    .q_count (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 0;

  task automatic cmp(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: heading, pulse and a plain FIFO of requested headings.
  int         mq[$];
  int         m_dir;
  int         m_turn;
  logic [3:0] m_prev;
  int         m_req;
  int         m_ref;
  bit         m_pop;
  bit         m_ok;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_dir  = 1;
      m_turn = 0;
      mq.delete();
      m_prev = 4'b1111;
    end else begin
      m_req = -1;
      for (int i = 3; i >= 0; i--)
        if (btn[i] && !m_prev[i]) m_req = i;
      m_ref = (mq.size() > 0) ? mq[$] : m_dir;
      m_pop = tick && (mq.size() > 0);
      m_ok  = (m_req >= 0) && (m_req != m_ref) && (((m_req + 2) % 4) != m_ref)
              && ((mq.size() < int'(QDEPTH)) || m_pop);
      m_turn = 0;
      if (m_pop) begin
        m_dir  = mq.pop_front();
        m_turn = 1;
      end
      if (m_ok) mq.push_back(m_req);
      m_prev = btn;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (started) begin
      cmp("model_dir", int'(dir), m_dir);
      cmp("model_turn", int'(turn), m_turn);
      cmp("model_q_count", int'(q_count), mq.size());
    end
  end

  task automatic cyc(input logic r, input logic [3:0] b, input logic t);
    rst_n = r;
    btn   = b;
    tick  = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input int d, input int tr, input int q);
    cmp({name, "_dir"}, int'(dir), d);
    cmp({name, "_turn"}, int'(turn), tr);
    cmp({name, "_q"}, int'(q_count), q);
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 4'b0001;
    tick  = 1'b0;
    // 1: reset with up held, then tick: held button ignored
    cyc(1'b0, 4'b0001, 1'b0);
    started = 1;
    cyc(1'b0, 4'b0001, 1'b0);
    lit("reset", 1, 0, 0);
    cyc(1'b1, 4'b0001, 1'b1);
    lit("held_thru_reset", 1, 0, 0);
    cyc(1'b1, 4'b0000, 1'b0);

    // 2: press up, tick applies it with a single turn pulse
    cyc(1'b1, 4'b0001, 1'b0);
    lit("up_queued", 1, 0, 1);
    cyc(1'b1, 4'b0000, 1'b1);
    lit("up_applied", 0, 1, 0);
    cyc(1'b1, 4'b0000, 1'b0);
    lit("turn_one_cycle", 0, 0, 0);
    cyc(1'b1, 4'b0010, 1'b0);
    cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0000, 1'b0);
    lit("back_right", 1, 0, 0);

    // 3: opposite and same headings rejected, perpendicular accepted
    cyc(1'b1, 4'b1000, 1'b0);
    lit("left_rejected", 1, 0, 0);
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b1, 4'b0010, 1'b0);
    lit("right_rejected", 1, 0, 0);
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b1, 4'b0100, 1'b0);
    lit("down_accepted", 1, 0, 1);
    cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0010, 1'b0);
    cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0000, 1'b0);
    lit("right_again", 1, 0, 0);

    // 4: fill queue [up, left]; third press rejected while full
    cyc(1'b1, 4'b0001, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b1, 4'b1000, 1'b0);
    lit("queue_two", 1, 0, 2);
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b1, 4'b0100, 1'b0);
    lit("full_reject", 1, 0, 2);
    cyc(1'b1, 4'b0000, 1'b0);

    // 5: push into full queue alongside a pop
    cyc(1'b1, 4'b0100, 1'b1);
    lit("push_pop_full", 0, 1, 2);
    cyc(1'b1, 4'b0000, 1'b1);
    lit("pop_left", 3, 1, 1);
    cyc(1'b1, 4'b0000, 1'b1);
    lit("pop_down", 2, 1, 0);
    cyc(1'b1, 4'b0000, 1'b1);
    lit("tick_empty", 2, 0, 0);

    // Up is opposite of down (rejected); right then up queue and drain
    cyc(1'b1, 4'b0001, 1'b0);
    lit("up_vs_down", 2, 0, 0);
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b1, 4'b0010, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b1, 4'b0001, 1'b0);
    lit("ref_is_tail", 2, 0, 2);
    cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b1, 4'b0000, 1'b1);
    lit("drain_up", 0, 1, 0);
    cyc(1'b1, 4'b0000, 1'b0);

    // 6: simultaneous right+left with dir=up: right wins, then reset mid-queue
    cyc(1'b1, 4'b1010, 1'b0);
    lit("prio_right", 0, 0, 1);
    cyc(1'b0, 4'b0000, 1'b1);
    lit("reset_flush", 1, 0, 0);
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b1, 4'b1010, 1'b0);
    lit("prio_right_rej", 1, 0, 0);
    cyc(1'b1, 4'b0000, 1'b0);

    // Press and tick on the same edge with an empty queue
    cyc(1'b1, 4'b0001, 1'b1);
    lit("press_tick_same", 1, 0, 1);
    cyc(1'b1, 4'b0000, 1'b1);
    lit("press_tick_next", 0, 1, 0);

    // Mixed traffic checked by the model alone
    for (int i = 0; i < 400; i++) begin
      logic [3:0] b;
      logic       t;
      logic       r;
      b = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      t = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 79) != 0);
      cyc(r, b, t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
